// File: rtl/deinterleaver_accum.sv
// Scatters per-weight contributions back onto left-side neurons using the sweepstart
// permutation, accumulates over all sweeps with saturation, then drains z neurons per word.
module deinterleaver_accum #(
  parameter int p     = 32,
  parameter int fo    = 2,
  parameter int z     = 8,
  parameter int width = 16,
  localparam int log_pbyz = (p == z) ? 1 : $clog2(p / z)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ss_load_valid,
  input  logic [log_pbyz-1:0]   ss_load_data,
  output logic                  ss_loaded,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [z*width-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [z*width-1:0]    out_data,
  output logic [log_pbyz-1:0]   out_addr,
  output logic                  busy
);

  localparam int PBYZ   = p / z;
  localparam int NCHUNK = fo * z;
  localparam int NBEAT  = p * fo / z;
  localparam int NW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic signed [width-1:0] SMAX = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, ACCUM, DRAIN} state_t;
  localparam state_t RESET_STATE = (p == z) ? ACCUM : LOAD;

  state_t                state_reg, state_next;
  logic [NW-1:0]         chunk_cnt_reg;
  logic [CW-1:0]         c_reg;
  logic [log_pbyz-1:0]   ss_reg [NCHUNK];
  logic                  ss_loaded_reg;
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic [log_pbyz-1:0]   out_addr_reg;

  logic                  load_fire, load_last, accept, beat_last;
  logic                  drain_fire, drain_last, drain_load;
  logic [log_pbyz-1:0]   drain_addr;
  logic [log_pbyz-1:0]   c_mod;
  int                    sweep_i;
  logic                  first_sweep;

  assign load_fire  = (state_reg == LOAD) && ss_load_valid;
  assign load_last  = load_fire && (chunk_cnt_reg == NW'(NCHUNK - 1));
  assign accept     = in_valid && in_ready_reg;
  assign beat_last  = accept && (c_reg == CW'(NBEAT - 1));
  assign drain_fire = (state_reg == DRAIN) && out_valid_reg && out_ready;
  assign drain_last = drain_fire && (out_addr_reg == log_pbyz'(PBYZ - 1));
  // Load word 0 on DRAIN entry, otherwise advance on every non-final handshake.
  assign drain_load = (state_reg == DRAIN) && (!out_valid_reg || (drain_fire && !drain_last));
  assign drain_addr = out_valid_reg ? out_addr_reg + 1'b1 : '0;

  always_comb begin
    sweep_i     = int'(c_reg) / PBYZ;
    c_mod       = log_pbyz'(int'(c_reg) % PBYZ);
    first_sweep = (sweep_i == 0);
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= RESET_STATE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (load_last)  state_next = ACCUM;
      ACCUM:   if (beat_last)  state_next = DRAIN;
      DRAIN:   if (drain_last) state_next = ACCUM;
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chunk_cnt_reg <= '0;
      c_reg         <= '0;
      ss_loaded_reg <= (p == z);
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      for (int i = 0; i < NCHUNK; i++) ss_reg[i] <= '0;
    end else begin
      if (load_fire) begin
        ss_reg[chunk_cnt_reg] <= ss_load_data;
        chunk_cnt_reg         <= chunk_cnt_reg + 1'b1;
      end
      if (load_last) ss_loaded_reg <= 1'b1;
      in_ready_reg <= (state_next == ACCUM);
      if (accept) c_reg <= beat_last ? '0 : c_reg + 1'b1;
      if (drain_load) begin
        out_valid_reg <= 1'b1;
        out_addr_reg  <= drain_addr;
      end else if (drain_last) begin
        out_valid_reg <= 1'b0;
        out_addr_reg  <= '0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < z; gi++) begin : g_lane
      logic signed [width-1:0] bank_reg [PBYZ];
      logic signed [width-1:0] lane_in;
      logic        [width-1:0] out_lane_reg;
      logic [log_pbyz-1:0]     t;
      logic signed [width:0]   sum;
      logic signed [width-1:0] sat;

      assign lane_in = in_data[gi*width +: width];
      // Entry offset wraps within the bank because the add is kept at log_pbyz bits.
      assign t   = ss_reg[NW'(sweep_i * z + gi)] + c_mod;
      assign sum = {lane_in[width-1], lane_in} + {bank_reg[t][width-1], bank_reg[t]};

      always_comb begin
        sat = sum[width-1:0];
        if (sum[width] != sum[width-1]) sat = sum[width] ? SMIN : SMAX;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int e = 0; e < PBYZ; e++) bank_reg[e] <= '0;
          out_lane_reg <= '0;
        end else begin
          if (accept) bank_reg[t] <= first_sweep ? lane_in : sat;
          if (drain_load) out_lane_reg <= bank_reg[drain_addr];
        end
      end

      assign out_data[gi*width +: width] = out_lane_reg;
    end
  endgenerate

  assign ss_loaded = ss_loaded_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign busy      = (state_reg == DRAIN) || ((state_reg == ACCUM) && (c_reg != '0));

endmodule

// File: tb/tb_deinterleaver_accum.sv
// Directed bench for deinterleaver_accum (p=32, fo=2, z=8, width=16) with hand-computed results.
module tb_deinterleaver_accum;

  logic         clk = 1'b0;
  logic         reset;
  logic         ss_load_valid;
  logic [1:0]   ss_load_data;
  logic         ss_loaded;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [1:0]   out_addr;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [127:0] beats [8];
  logic [127:0] expw  [4];

  deinterleaver_accum #(.p(32), .fo(2), .z(8), .width(16)) dut (
    .clk(clk), .reset(reset),
    .ss_load_valid(ss_load_valid), .ss_load_data(ss_load_data), .ss_loaded(ss_loaded),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] splat(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ss_load_valid = 1'b0; ss_load_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // All chunks zero except chunk 0 and chunk 8 (lane 0 of sweeps 0 and 1).
  task automatic load_chunks(input logic [1:0] v0, input logic [1:0] v8);
    for (int n = 0; n < 16; n++) begin
      ss_load_valid = 1'b1;
      ss_load_data  = (n == 0) ? v0 : ((n == 8) ? v8 : 2'd0);
      if (n == 15) check("ss_loaded_before_last", ss_loaded, 0);
      tick();
    end
    ss_load_valid = 1'b0;
    check("ss_loaded_after_last", ss_loaded, 1);
    check("in_ready_after_load", in_ready, 1);
  endtask

  task automatic send_beats(input bit stall);
    check("busy_idle", busy, 0);
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = beats[c];
      check("in_ready_accum", in_ready, 1);
      tick();
      check("busy_after_beat", busy, 1);
      if (stall && c < 7) begin
        in_valid = 1'b0;
        in_data  = ~beats[c];
        tick();
        check("busy_stall", busy, 1);
      end
    end
    in_valid = 1'b0;
    check("out_valid_latency1", out_valid, 0);
    check("in_ready_drain", in_ready, 0);
    tick();
  endtask

  task automatic drain_check(input int bp_word);
    for (int w = 0; w < 4; w++) begin
      check("out_valid", out_valid, 1);
      check("out_addr", out_addr, w);
      check($sformatf("out_data_w%0d", w), out_data, expw[w]);
      check("busy_drain", busy, 1);
      if (w == bp_word) begin
        out_ready = 1'b0;
        repeat (5) begin
          tick();
          check("bp_out_valid", out_valid, 1);
          check("bp_out_addr", out_addr, w);
          check("bp_out_data", out_data, expw[w]);
          check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check("out_valid_end", out_valid, 0);
    check("busy_end", busy, 0);
    check("in_ready_end", in_ready, 1);
  endtask

  initial begin
    logic [127:0] w;

    // Reset state
    do_reset();
    check("rst_ss_loaded", ss_loaded, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    $display("[TB] reset state checked");

    // Scenario 1: zero chunks, every lane 1 -> every neuron 2
    load_chunks(2'd0, 2'd0);
    for (int c = 0; c < 8; c++) beats[c] = splat(16'd1);
    for (int i = 0; i < 4; i++) expw[i] = splat(16'd2);
    send_beats(1'b0);
    drain_check(-1);
    $display("[TB] junction all-ones done");

    // Scenario 5: same data with in_valid toggling every other cycle
    send_beats(1'b1);
    drain_check(-1);
    $display("[TB] junction with input stalls done");

    // Scenario 3: saturation on lanes 3 (positive) and 4 (negative)
    for (int c = 0; c < 8; c++) beats[c] = '0;
    beats[0][3*16 +: 16] = 16'h7FFF;  beats[0][4*16 +: 16] = 16'h8000;
    beats[4][3*16 +: 16] = 16'h0001;  beats[4][4*16 +: 16] = 16'hFFFF;
    w = '0; w[3*16 +: 16] = 16'h7FFF; w[4*16 +: 16] = 16'h8000;
    expw[0] = w; expw[1] = '0; expw[2] = '0; expw[3] = '0;
    send_beats(1'b0);
    drain_check(-1);
    $display("[TB] saturation junction done");

    // Scenario 4: beat c carries c+1 in every lane -> entry t = (t+1)+(t+5)
    for (int c = 0; c < 8; c++) beats[c] = splat(16'(c + 1));
    expw[0] = splat(16'd6);  expw[1] = splat(16'd8);
    expw[2] = splat(16'd10); expw[3] = splat(16'd12);
    send_beats(1'b0);
    drain_check(1);
    $display("[TB] backpressure junction done");
    for (int c = 0; c < 8; c++) beats[c] = splat(16'd1);
    for (int i = 0; i < 4; i++) expw[i] = splat(16'd2);
    send_beats(1'b0);
    drain_check(-1);
    $display("[TB] fresh second junction done");

    // Scenario 2a: only chunk 0 = 1 -> sweep 0 lane 0 rotated by 1, sweep 1 unrotated
    do_reset();
    load_chunks(2'd1, 2'd0);
    for (int c = 0; c < 8; c++) beats[c] = '0;
    beats[0][15:0] = 16'd5; beats[1][15:0] = 16'd7;
    beats[4][15:0] = 16'd3; beats[5][15:0] = 16'd1;
    expw[0] = 128'd3; expw[1] = 128'd6; expw[2] = 128'd7; expw[3] = 128'd0;
    send_beats(1'b0);
    drain_check(-1);
    $display("[TB] permuted junction (chunk0) done");

    // Scenario 2b: chunk 0 and chunk 8 = 1 -> both sweeps rotated for lane 0
    do_reset();
    load_chunks(2'd1, 2'd1);
    expw[0] = 128'd0; expw[1] = 128'd8; expw[2] = 128'd8; expw[3] = 128'd0;
    send_beats(1'b0);
    drain_check(-1);
    $display("[TB] permuted junction (chunk0, chunk8) done");

    // Scenario 6: reset while beat c=5 is presented
    do_reset();
    load_chunks(2'd0, 2'd0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = splat(16'd9);
      tick();
    end
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("midrst_ss_loaded", ss_loaded, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    tick();
    check("midrst_in_ready_load", in_ready, 0);
    load_chunks(2'd0, 2'd0);
    for (int c = 0; c < 8; c++) beats[c] = splat(16'd1);
    for (int i = 0; i < 4; i++) expw[i] = splat(16'd2);
    send_beats(1'b0);
    drain_check(-1);
    $display("[TB] rerun after mid-operation reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
